// File: rtl/prim_crc32_check.sv
// Receive-side CRC32 (IEEE, reflected) frame checker: folds every byte including
// the little-endian trailer and reports residue match, length error and beat count.
module prim_crc32_check #(
    parameter  int unsigned BytesPerWord = 4,
    parameter  int unsigned MaxWords     = 1024,
    localparam int unsigned CntW         = $clog2(MaxWords + 1),
    localparam int unsigned DataW        = BytesPerWord * 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    input  logic [DataW-1:0] data_i,
    input  logic             data_last_i,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic             crc_ok_o,
    output logic             len_err_o,
    output logic [31:0]      crc_o,
    output logic [CntW-1:0]  word_cnt_o
);

    localparam logic [31:0]     Poly    = 32'hEDB8_8320;
    localparam logic [31:0]     Residue = 32'hDEBB_20E3;
    localparam logic [CntW-1:0] CntLim  = CntW'(MaxWords);
    localparam logic [CntW-1:0] CntSat  = CntW'(MaxWords + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESULT
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     crc_q, crc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            data_ready_q, data_ready_d;
    logic            result_valid_q, result_valid_d;
    logic            crc_ok_q, crc_ok_d;
    logic            len_err_q, len_err_d;
    logic [31:0]     crc_out_q, crc_out_d;
    logic [CntW-1:0] word_cnt_q, word_cnt_d;

    logic            beat;
    logic [31:0]     crc_fold;
    logic [CntW-1:0] cnt_inc;
    logic            len_bad;

    // Bit-serial form of the byte-table fold c = (c>>8) ^ T[c[7:0]^byte], byte 0 first.
    function automatic logic [31:0] fold(input logic [31:0] c_in, input logic [DataW-1:0] d);
        logic [31:0] c;
        c = c_in;
        for (int unsigned i = 0; i < BytesPerWord; i++) begin
            c = c ^ {24'd0, d[8*i +: 8]};
            for (int unsigned b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ Poly) : (c >> 1);
            end
        end
        return c;
    endfunction

    always_comb begin
        beat     = data_valid_i & data_ready_q;
        crc_fold = fold(crc_q, data_i);
        cnt_inc  = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
        len_bad  = ((32'(cnt_inc) * BytesPerWord) < 32'd4) || (cnt_inc > CntLim);

        state_d        = state_q;
        crc_d          = crc_q;
        cnt_d          = cnt_q;
        data_ready_d   = data_ready_q;
        result_valid_d = result_valid_q;
        crc_ok_d       = crc_ok_q;
        len_err_d      = len_err_q;
        crc_out_d      = crc_out_q;
        word_cnt_d     = word_cnt_q;

        if (clear_i) begin
            state_d        = IDLE;
            crc_d          = '1;
            cnt_d          = '0;
            data_ready_d   = 1'b1;
            result_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                // IDLE shares the BUSY path: crc_q/cnt_q already hold their init values there.
                IDLE, BUSY: begin
                    if (beat) begin
                        crc_d = crc_fold;
                        cnt_d = cnt_inc;
                        if (data_last_i) begin
                            state_d        = RESULT;
                            data_ready_d   = 1'b0;
                            result_valid_d = 1'b1;
                            crc_out_d      = ~crc_fold;
                            word_cnt_d     = cnt_inc;
                            len_err_d      = len_bad;
                            crc_ok_d       = (crc_fold == Residue) & ~len_bad;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
                RESULT: begin
                    if (result_ready_i) begin
                        state_d        = IDLE;
                        crc_d          = '1;
                        cnt_d          = '0;
                        data_ready_d   = 1'b1;
                        result_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d        = IDLE;
                    crc_d          = '1;
                    cnt_d          = '0;
                    data_ready_d   = 1'b1;
                    result_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            crc_q          <= '1;
            cnt_q          <= '0;
            data_ready_q   <= 1'b1;
            result_valid_q <= 1'b0;
            crc_ok_q       <= 1'b0;
            len_err_q      <= 1'b0;
            crc_out_q      <= '0;
            word_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            crc_q          <= crc_d;
            cnt_q          <= cnt_d;
            data_ready_q   <= data_ready_d;
            result_valid_q <= result_valid_d;
            crc_ok_q       <= crc_ok_d;
            len_err_q      <= len_err_d;
            crc_out_q      <= crc_out_d;
            word_cnt_q     <= word_cnt_d;
        end
    end

    assign data_ready_o   = data_ready_q;
    assign result_valid_o = result_valid_q;
    assign crc_ok_o       = crc_ok_q;
    assign len_err_o      = len_err_q;
    assign crc_o          = crc_out_q;
    assign word_cnt_o     = word_cnt_q;

endmodule

// File: tb/tb_prim_crc32_check.sv
// Bench for prim_crc32_check: default instance plus a MaxWords=4 instance on shared
// stimulus, checked against a byte-stream CRC32 reference model.
module tb_prim_crc32_check;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        data_valid_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        data_last_i = 1'b0;
    logic        result_ready_i = 1'b0;

    logic        dr0, rv0, ok0, le0;
    logic [31:0] crc0;
    logic [10:0] cnt0;
    logic        dr1, rv1, ok1, le1;
    logic [31:0] crc1;
    logic [2:0]  cnt1;

    int unsigned total = 0;
    int unsigned bad = 0;

    typedef struct {
        logic        ok0;
        logic        len0;
        logic        ok1;
        logic        len1;
        logic [31:0] crc;
        int unsigned cnt0;
        int unsigned cnt1;
    } exp_t;

    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    prim_crc32_check #(.BytesPerWord(4), .MaxWords(1024)) u_dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .data_valid_i(data_valid_i), .data_ready_o(dr0), .data_i(data_i),
        .data_last_i(data_last_i), .result_valid_o(rv0), .result_ready_i(result_ready_i),
        .crc_ok_o(ok0), .len_err_o(le0), .crc_o(crc0), .word_cnt_o(cnt0)
    );

    prim_crc32_check #(.BytesPerWord(4), .MaxWords(4)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .data_valid_i(data_valid_i), .data_ready_o(dr1), .data_i(data_i),
        .data_last_i(data_last_i), .result_valid_o(rv1), .result_ready_i(result_ready_i),
        .crc_ok_o(ok1), .len_err_o(le1), .crc_o(crc1), .word_cnt_o(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // zlib-style CRC32 of a byte stream
    function automatic logic [31:0] crc32(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic exp_t expect_of(input logic [31:0] w[$]);
        exp_t        e;
        logic [7:0]  pay[$];
        logic [7:0]  all[$];
        logic [31:0] tw;
        int unsigned n;
        logic        good;
        n = w.size();
        for (int unsigned i = 0; i < n; i++) begin
            tw = w[i];
            for (int j = 0; j < 4; j++) begin
                all.push_back(tw[8*j +: 8]);
                if (i + 1 < n) pay.push_back(tw[8*j +: 8]);
            end
        end
        good   = (crc32(pay) == w[n-1]);
        e.crc  = crc32(all);
        e.len0 = (n > 1024);
        e.ok0  = good && !e.len0;
        e.cnt0 = (n > 1025) ? 1025 : n;
        e.len1 = (n > 4);
        e.ok1  = good && !e.len1;
        e.cnt1 = (n > 5) ? 5 : n;
        return e;
    endfunction

    function automatic void build_good(input int unsigned n, output logic [31:0] w[$]);
        logic [7:0]  pay[$];
        logic [31:0] r;
        w = {};
        for (int unsigned i = 0; i + 1 < n; i++) begin
            r = $urandom;
            w.push_back(r);
            for (int j = 0; j < 4; j++) pay.push_back(r[8*j +: 8]);
        end
        w.push_back(crc32(pay));
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic compare(input exp_t e, input string tag);
        check({tag, "_rv1"}, rv1, 1);
        check({tag, "_ok0"}, ok0, e.ok0);
        check({tag, "_len0"}, le0, e.len0);
        check({tag, "_crc0"}, crc0, e.crc);
        check({tag, "_cnt0"}, 32'(cnt0), e.cnt0);
        check({tag, "_ok1"}, ok1, e.ok1);
        check({tag, "_len1"}, le1, e.len1);
        check({tag, "_crc1"}, crc1, e.crc);
        check({tag, "_cnt1"}, 32'(cnt1), e.cnt1);
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_dr0"}, dr0, 1);
        check({tag, "_rv0"}, rv0, 0);
        check({tag, "_ok0"}, ok0, 0);
        check({tag, "_len0"}, le0, 0);
        check({tag, "_crc0"}, crc0, 0);
        check({tag, "_cnt0"}, 32'(cnt0), 0);
        check({tag, "_dr1"}, dr1, 1);
        check({tag, "_rv1"}, rv1, 0);
        check({tag, "_crc1"}, crc1, 0);
        check({tag, "_cnt1"}, 32'(cnt1), 0);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last, input int unsigned gap);
        int unsigned guard;
        repeat (gap) tick();
        data_valid_i = 1'b1;
        data_i       = d;
        data_last_i  = last;
        guard        = 0;
        while (!dr0) begin
            tick();
            guard++;
            if (guard > 200) begin
                check("beat_timeout", guard, 0);
                break;
            end
        end
        tick();
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
        data_i       = $urandom;
    endtask

    task automatic take_result();
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] w[$], input string tag);
        foreach (w[i]) send_beat(w[i], (i == w.size() - 1), 0);
        check({tag, "_lat"}, rv0, 1);
        compare(expect_of(w), tag);
        take_result();
    endtask

    logic [31:0] w[$];
    logic [31:0] tw;

    initial begin
        repeat (2) tick();
        reset_vals("reset");
        #2 rst_ni = 1'b1;
        tick();

        // good two-beat frame, then held result with a pending single-beat frame
        send_beat(32'h0, 0, 0);
        check("t1_before", rv0, 0);
        send_beat(32'h2144_DF1C, 1, 0);
        check("t1_lat", rv0, 1);
        compare(expect_of('{32'h0, 32'h2144_DF1C}), "t1");
        check("t1_okconst", ok0, 1);
        data_valid_i = 1'b1;
        data_i       = 32'h0;
        data_last_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4a_ready", dr0, 0);
            check("t4a_hold_crc", crc0, 32'h2144_DF1C);
            check("t4a_hold_cnt", 32'(cnt0), 2);
            tick();
        end
        take_result();
        check("t4a_idle_rv", rv0, 0);
        check("t4a_idle_dr", dr0, 1);
        tick();
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
        check("t2_lat", rv0, 1);
        compare(expect_of('{32'h0}), "t2");
        take_result();

        // corrupted trailer and flipped data bit
        run_frame('{32'h0, 32'h2144_DF1D}, "t3_trl");
        check("t3_trl_ok", ok0, 0);
        run_frame('{32'h0000_0100, 32'h2144_DF1C}, "t3_flip");

        // 6-beat good frame: too long for the MaxWords=4 instance
        build_good(6, w);
        run_frame(w, "t4b");

        // clear mid-frame; the beat presented with clear is dropped
        for (int i = 0; i < 3; i++) send_beat($urandom, 0, 0);
        clear_i      = 1'b1;
        data_valid_i = 1'b1;
        data_last_i  = 1'b1;
        tick();
        clear_i      = 1'b0;
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
        check("t5a_rv", rv0, 0);
        check("t5a_dr", dr0, 1);
        check("t5a_keep_cnt", 32'(cnt0), 6);
        tick();
        check("t5a_drop", rv0, 0);
        run_frame('{32'h0, 32'h2144_DF1C}, "t5a");

        // clear while a result is pending
        send_beat(32'h0, 1, 0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("t5a_res_clear_rv", rv0, 0);
        check("t5a_res_clear_dr", dr0, 1);

        // asynchronous reset mid-frame
        send_beat(32'h0, 0, 0);
        send_beat(32'h5, 0, 0);
        #2 rst_ni = 1'b0;
        #1;
        reset_vals("t5b");
        tick();
        #2 rst_ni = 1'b1;
        tick();
        run_frame('{32'h0, 32'h2144_DF1C}, "t5b_after");

        // randomized frames with valid/ready gaps
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    int unsigned n;
                    n = $urandom_range(1, 64);
                    build_good(n, w);
                    if ($urandom_range(0, 2) == 0) begin
                        int unsigned k;
                        k = $urandom_range(0, n - 1);
                        tw = w[k];
                        tw[$urandom_range(0, 31)] ^= 1'b1;
                        w[k] = tw;
                    end
                    sb.push_back(expect_of(w));
                    foreach (w[i])
                        send_beat(w[i], (i == n - 1),
                                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
                end
            end
            begin
                int unsigned got;
                int unsigned guard;
                got   = 0;
                guard = 0;
                while (got < 40 && guard < 30000) begin
                    if (rv0) begin
                        if (sb.size() == 0) begin
                            check("rand_spurious", 1, 0);
                            tick();
                        end else begin
                            compare(sb[0], "rand");
                            if ($urandom_range(0, 1) == 1) begin
                                take_result();
                                void'(sb.pop_front());
                                got++;
                            end else begin
                                tick();
                            end
                        end
                    end else begin
                        tick();
                    end
                    guard++;
                end
                check("rand_done", got, 40);
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
